// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes and the ID/EX buffer occupancy states.
package cpu_pkg;

   localparam int ALU_CTRL_W = 6;

   localparam logic [ALU_CTRL_W-1:0] ALU_NOP  = 6'd0;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 6'd1;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 6'd2;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 6'd7;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 6'd8;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 6'd11;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 6'd12;
   localparam logic [ALU_CTRL_W-1:0] ALU_BNE  = 6'd15;
   localparam logic [ALU_CTRL_W-1:0] ALU_BEQ  = 6'd16;
   localparam logic [ALU_CTRL_W-1:0] ALU_BLE  = 6'd17;
   localparam logic [ALU_CTRL_W-1:0] ALU_BLT  = 6'd18;
   localparam logic [ALU_CTRL_W-1:0] ALU_BGE  = 6'd19;
   localparam logic [ALU_CTRL_W-1:0] ALU_BGT  = 6'd20;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 6'd24;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 6'd25;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_FULL
   } buf_state_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forward select: takes the committed ALU result when it targets this
// source register; register 0 is never forwarded.
module fwd_mux #(
   parameter int size    = 32,
   parameter int REGBITS = 5
) (
   input  logic               fwd_valid,
   input  logic [REGBITS-1:0] fwd_rd,
   input  logic [size-1:0]    fwd_data,
   input  logic [REGBITS-1:0] idx,
   input  logic [size-1:0]    val,
   output logic [size-1:0]    y
);

   always_comb begin
      y = val;
      if (fwd_valid && (fwd_rd != '0) && (fwd_rd == idx))
         y = fwd_data;
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: resolves operands at capture and holds them in a
// main + skid buffer so in_ready can be registered without losing throughput.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int size    = 32,
   parameter int REGBITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_CTRL_W-1:0] in_alucontrol,
   input  logic [REGBITS-1:0]    in_rs_idx,
   input  logic [REGBITS-1:0]    in_rt_idx,
   input  logic [size-1:0]       in_rs_val,
   input  logic [size-1:0]       in_rt_val,
   input  logic [size-1:0]       in_imm,
   input  logic                  in_use_imm,
   input  logic [REGBITS-1:0]    in_rd,
   input  logic                  in_wb_en,
   input  logic                  fwd_valid,
   input  logic [REGBITS-1:0]    fwd_rd,
   input  logic [size-1:0]       fwd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [size-1:0]       a,
   output logic [size-1:0]       b,
   output logic [ALU_CTRL_W-1:0] alucontrol,
   output logic [REGBITS-1:0]    out_rd,
   output logic                  out_wb_en
);

   logic [size-1:0] res_a;
   logic [size-1:0] rt_fwd;
   logic [size-1:0] res_b;
   logic            accept;
   logic            issue;

   buf_state_t            state;
   logic [size-1:0]       skid_a;
   logic [size-1:0]       skid_b;
   logic [ALU_CTRL_W-1:0] skid_alu;
   logic [REGBITS-1:0]    skid_rd;
   logic                  skid_wb;

   fwd_mux #(.size(size), .REGBITS(REGBITS)) u_fwd_a (
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data),
      .idx       (in_rs_idx),
      .val       (in_rs_val),
      .y         (res_a)
   );

   fwd_mux #(.size(size), .REGBITS(REGBITS)) u_fwd_b (
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data),
      .idx       (in_rt_idx),
      .val       (in_rt_val),
      .y         (rt_fwd)
   );

   always_comb begin
      res_b  = in_use_imm ? in_imm : rt_fwd;
      accept = in_valid && in_ready;
      issue  = out_valid && out_ready;
   end

   // out_valid / in_ready are registered copies of (state != EMPTY / != FULL)
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BUF_EMPTY;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         a          <= '0;
         b          <= '0;
         alucontrol <= ALU_NOP;
         out_rd     <= '0;
         out_wb_en  <= 1'b0;
         skid_a     <= '0;
         skid_b     <= '0;
         skid_alu   <= ALU_NOP;
         skid_rd    <= '0;
         skid_wb    <= 1'b0;
      end else if (flush) begin
         state      <= BUF_EMPTY;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         a          <= '0;
         b          <= '0;
         alucontrol <= ALU_NOP;
         out_rd     <= '0;
         out_wb_en  <= 1'b0;
      end else begin
         case (state)
            BUF_EMPTY: begin
               if (accept) begin
                  a          <= res_a;
                  b          <= res_b;
                  alucontrol <= in_alucontrol;
                  out_rd     <= in_rd;
                  out_wb_en  <= in_wb_en;
                  out_valid  <= 1'b1;
                  state      <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (accept && issue) begin
                  a          <= res_a;
                  b          <= res_b;
                  alucontrol <= in_alucontrol;
                  out_rd     <= in_rd;
                  out_wb_en  <= in_wb_en;
               end else if (accept) begin
                  skid_a   <= res_a;
                  skid_b   <= res_b;
                  skid_alu <= in_alucontrol;
                  skid_rd  <= in_rd;
                  skid_wb  <= in_wb_en;
                  in_ready <= 1'b0;
                  state    <= BUF_FULL;
               end else if (issue) begin
                  out_valid <= 1'b0;
                  state     <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (issue) begin
                  a          <= skid_a;
                  b          <= skid_b;
                  alucontrol <= skid_alu;
                  out_rd     <= skid_rd;
                  out_wb_en  <= skid_wb;
                  in_ready   <= 1'b1;
                  state      <= BUF_ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= BUF_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues hand-computed expected
// ops on accept, the monitor pops and compares on every issue.
module tb_id_ex_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_alucontrol = '0;
   logic [4:0]  in_rs_idx = '0;
   logic [4:0]  in_rt_idx = '0;
   logic [31:0] in_rs_val = '0;
   logic [31:0] in_rt_val = '0;
   logic [31:0] in_imm = '0;
   logic        in_use_imm = 1'b0;
   logic [4:0]  in_rd = '0;
   logic        in_wb_en = 1'b0;
   logic        fwd_valid = 1'b0;
   logic [4:0]  fwd_rd = '0;
   logic [31:0] fwd_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] a;
   logic [31:0] b;
   logic [5:0]  alucontrol;
   logic [4:0]  out_rd;
   logic        out_wb_en;

   always #5 clk = ~clk;

   id_ex_stage #(.size(32), .REGBITS(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_alucontrol (in_alucontrol),
      .in_rs_idx     (in_rs_idx),
      .in_rt_idx     (in_rt_idx),
      .in_rs_val     (in_rs_val),
      .in_rt_val     (in_rt_val),
      .in_imm        (in_imm),
      .in_use_imm    (in_use_imm),
      .in_rd         (in_rd),
      .in_wb_en      (in_wb_en),
      .fwd_valid     (fwd_valid),
      .fwd_rd        (fwd_rd),
      .fwd_data      (fwd_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .a             (a),
      .b             (b),
      .alucontrol    (alucontrol),
      .out_rd        (out_rd),
      .out_wb_en     (out_wb_en)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  alu;
      logic [4:0]  rd;
      logic        wb;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   issues = 0;
   int   cyc = 0;
   int   rdy_drops = 0;
   logic watch_rdy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (watch_rdy && !in_ready) rdy_drops++;
      if (!rst && out_valid && out_ready) begin
         issues++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got a=%0h alucontrol=%0h rd=%0d expected no issue",
                     a, alucontrol, out_rd);
         end else begin
            e = sb.pop_front();
            chk("issue_a", a, e.a);
            chk("issue_b", b, e.b);
            chk("issue_alucontrol", 32'(alucontrol), 32'(e.alu));
            chk("issue_rd", 32'(out_rd), 32'(e.rd));
            chk("issue_wb_en", 32'(out_wb_en), 32'(e.wb));
         end
      end
   end

   // Drive one op and wait (bounded) until it is accepted; call at posedge+#1.
   task automatic send(input logic [5:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                       input logic ui, input logic [4:0] rd, input logic wb,
                       input logic [31:0] ea, input logic [31:0] eb);
      int n;
      exp_t e;
      n = 0;
      in_valid = 1'b1;
      in_alucontrol = alu;
      in_rs_idx = rs;
      in_rt_idx = rt;
      in_rs_val = rsv;
      in_rt_val = rtv;
      in_imm = imm;
      in_use_imm = ui;
      in_rd = rd;
      in_wb_en = wb;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1 (rd=%0d)", rd);
      end else begin
         e = '{a: ea, b: eb, alu: alu, rd: rd, wb: wb};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation got no end expected finish");
      $fatal(1);
   end

   initial begin
      int c0;
      int i0;

      // reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_alucontrol", 32'(alucontrol), 0);
      chk("rst_out_rd", 32'(out_rd), 0);
      chk("rst_out_wb_en", 32'(out_wb_en), 0);
      @(posedge clk);
      #1;

      // single ADD, one-cycle latency
      out_ready = 1'b1;
      send(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 1'b1, 32'd5, 32'd7);
      @(negedge clk);
      chk("add_out_valid", 32'(out_valid), 1);
      chk("add_a", a, 5);
      chk("add_b", b, 7);
      chk("add_alucontrol", 32'(alucontrol), 1);
      @(posedge clk);
      #1;

      // forwarding
      fwd_valid = 1'b1;
      fwd_rd = 5'd3;
      fwd_data = 32'hDEAD;
      send(ALU_OR,  5'd3, 5'd3, 32'h11, 32'h22, 32'd4, 1'b1, 5'd5, 1'b1, 32'hDEAD, 32'd4);
      send(ALU_SUB, 5'd3, 5'd3, 32'h11, 32'h22, 32'd4, 1'b0, 5'd6, 1'b1, 32'hDEAD, 32'hDEAD);
      send(ALU_SLT, 5'd2, 5'd3, 32'h11, 32'h22, 32'd4, 1'b0, 5'd7, 1'b0, 32'h11, 32'hDEAD);
      fwd_rd = 5'd0;
      send(ALU_AND, 5'd0, 5'd0, 32'h33, 32'h44, 32'd4, 1'b0, 5'd8, 1'b1, 32'h33, 32'h44);
      fwd_rd = 5'd3;
      fwd_valid = 1'b0;
      send(ALU_BEQ, 5'd3, 5'd3, 32'h55, 32'h66, 32'd4, 1'b0, 5'd0, 1'b0, 32'h55, 32'h66);
      repeat (3) @(posedge clk);
      #1;
      chk("fwd_drained", 32'(sb.size()), 0);

      // stall: fill main and skid, third op waits, then drain in order
      out_ready = 1'b0;
      fork
         begin
            send(ALU_SLL, 5'd1, 5'd2, 32'h101, 32'h102, 32'd0, 1'b0, 5'd9,  1'b1, 32'h101, 32'h102);
            send(ALU_SRL, 5'd1, 5'd2, 32'h201, 32'h202, 32'd0, 1'b0, 5'd10, 1'b1, 32'h201, 32'h202);
            send(ALU_SLTU,5'd1, 5'd2, 32'h301, 32'h302, 32'd0, 1'b0, 5'd11, 1'b0, 32'h301, 32'h302);
         end
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 0);
            chk("full_out_valid", 32'(out_valid), 1);
            chk("full_head_a", a, 32'h101);
            repeat (2) @(negedge clk);
            chk("stall_hold_a", a, 32'h101);
            chk("stall_hold_b", b, 32'h102);
            chk("stall_hold_rd", 32'(out_rd), 9);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      chk("stall_drained", 32'(sb.size()), 0);

      // flush while FULL with an op presented
      out_ready = 1'b0;
      send(ALU_BNE, 5'd1, 5'd2, 32'h401, 32'h402, 32'd0, 1'b0, 5'd12, 1'b1, 32'h401, 32'h402);
      send(ALU_BLT, 5'd1, 5'd2, 32'h501, 32'h502, 32'd0, 1'b0, 5'd13, 1'b1, 32'h501, 32'h502);
      in_valid = 1'b1;
      in_alucontrol = ALU_BGT;
      in_rs_val = 32'h601;
      in_rd = 5'd14;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      i0 = issues;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_a", a, 0);
      chk("flush_b", b, 0);
      chk("flush_alucontrol", 32'(alucontrol), 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("flush_no_issue", 32'(issues - i0), 0);

      // flush while EMPTY: the accept in the flush cycle is discarded
      in_valid = 1'b1;
      in_alucontrol = ALU_BGE;
      in_rd = 5'd15;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_accept_out_valid", 32'(out_valid), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("flush_accept_no_issue", 32'(issues - i0), 0);

      // full throughput
      watch_rdy = 1'b1;
      c0 = cyc;
      i0 = issues;
      for (int i = 0; i < 10; i++)
         send(ALU_ADD, 5'(i), 5'(i + 1), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'd0, 1'b0,
              5'(i + 1), 1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      chk("stream_cycles", 32'(cyc - c0), 10);
      repeat (3) @(posedge clk);
      #1;
      watch_rdy = 1'b0;
      chk("stream_in_ready_drops", 32'(rdy_drops), 0);
      chk("stream_issues", 32'(issues - i0), 10);
      chk("stream_drained", 32'(sb.size()), 0);

      // reset mid-operation with both entries full
      out_ready = 1'b0;
      send(ALU_BLE, 5'd1, 5'd2, 32'h701, 32'h702, 32'd0, 1'b0, 5'd16, 1'b1, 32'h701, 32'h702);
      send(ALU_SUB, 5'd1, 5'd2, 32'h801, 32'h802, 32'd0, 1'b0, 5'd17, 1'b1, 32'h801, 32'h802);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      i0 = issues;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_a", a, 0);
      chk("midrst_out_rd", 32'(out_rd), 0);
      chk("midrst_out_wb_en", 32'(out_wb_en), 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_issue", 32'(issues - i0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
